// File: rtl/deadlock_block_aggregator.sv
// ---------------------------------------------------------------------------
// deadlock_block_aggregator
//
// Collects the `block` outputs of NUM_MON deadlock monitors and a global
// progress strobe. A deadlock is declared only after THRESH consecutive
// cycles in which at least one monitor is blocking and nothing progressed.
// Diagnostics (first blocking monitor, accumulated blocking mask, timestamp
// of detection) are latched and held until clear or reset.
//
// Ports:
//   clock          in   clock
//   reset          in   synchronous, active-high reset
//   mon_block      in   [NUM_MON]  bit i = block output of monitor i
//   progress       in   any stream/ap handshake completed this cycle
//   clear          in   synchronous re-arm back to IDLE
//   deadlock       out  sticky deadlock flag
//   deadlock_pulse out  one-cycle strobe when deadlock rises
//   first_idx      out  [IDX_W]    lowest blocking index, first cycle of episode
//   blocked_mask   out  [NUM_MON]  OR of mon_block over the episode
//   detect_cycle   out  [CNT_W]    cycle stamp of the THRESH-th blocked cycle
//   state          out  [2]        0=IDLE 1=SUSPECT 2=DEADLOCK
// ---------------------------------------------------------------------------
module deadlock_block_aggregator #(
    parameter int NUM_MON = 4,
    parameter int THRESH  = 1000,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               progress,
    input  logic               clear,
    output logic               deadlock,
    output logic               deadlock_pulse,
    output logic [IDX_W-1:0]   first_idx,
    output logic [NUM_MON-1:0] blocked_mask,
    output logic [CNT_W-1:0]   detect_cycle,
    output logic [1:0]         state
);

    localparam int SC_W = $clog2(THRESH + 1);
    localparam logic [SC_W:0] THRESH_C = (SC_W + 1)'(THRESH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DEADLOCK = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SC_W-1:0]    stall_q, stall_d;
    logic [NUM_MON-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   first_q, first_d;
    logic [CNT_W-1:0]   det_q, det_d;
    logic               dl_q, dl_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   cyc_q;

    logic               blocked_c;
    logic [SC_W:0]      stall_inc;
    logic               reach_thresh;
    logic               enter_dl;

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_MON-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Progress in the same cycle as a block cancels it.
    assign blocked_c    = (|mon_block) & ~progress;
    // One bit wider than the counter so the compare never overflows.
    assign stall_inc    = {1'b0, stall_q} + (SC_W + 1)'(1);
    assign reach_thresh = (stall_inc >= THRESH_C);

    // State register and free-running timestamp
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_q + CNT_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (blocked_c) state_d = (THRESH <= 1) ? ST_DEADLOCK : ST_SUSPECT;
                end
                ST_SUSPECT: begin
                    if (!blocked_c)       state_d = ST_IDLE;
                    else if (reach_thresh) state_d = ST_DEADLOCK;
                end
                ST_DEADLOCK: state_d = ST_DEADLOCK;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    assign enter_dl = (state_d == ST_DEADLOCK) && (state_q != ST_DEADLOCK);

    // Counter and diagnostic next values
    always_comb begin
        stall_d = stall_q;
        mask_d  = mask_q;
        first_d = first_q;
        det_d   = det_q;
        dl_d    = dl_q;
        pulse_d = 1'b0;
        if (clear) begin
            stall_d = '0;
            mask_d  = '0;
            first_d = '0;
            det_d   = '0;
            dl_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (blocked_c) begin
                        stall_d = SC_W'(1);
                        mask_d  = mon_block;
                        first_d = lowest_set(mon_block);
                    end
                end
                ST_SUSPECT: begin
                    if (blocked_c) begin
                        mask_d = mask_q | mon_block;
                        // stall_inc never exceeds THRESH here, so it fits.
                        stall_d = stall_inc[SC_W-1:0];
                    end else begin
                        stall_d = '0;
                        mask_d  = '0;
                        first_d = '0;
                    end
                end
                default: ;
            endcase
            if (enter_dl) begin
                dl_d    = 1'b1;
                pulse_d = 1'b1;
                det_d   = cyc_q;
            end
        end
    end

    // Diagnostic registers
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            mask_q  <= '0;
            first_q <= '0;
            det_q   <= '0;
            dl_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            mask_q  <= mask_d;
            first_q <= first_d;
            det_q   <= det_d;
            dl_q    <= dl_d;
            pulse_q <= pulse_d;
        end
    end

    // Outputs straight from registers
    always_comb begin
        deadlock       = dl_q;
        deadlock_pulse = pulse_q;
        first_idx      = first_q;
        blocked_mask   = mask_q;
        detect_cycle   = det_q;
        state          = state_q;
    end

endmodule

// File: tb/tb_deadlock_block_aggregator.sv
// ---------------------------------------------------------------------------
// tb_deadlock_block_aggregator
//
// Three instances share the same inputs: a THRESH=4 reference configuration,
// a THRESH=1 corner and a CNT_W=4 instance for timestamp wrap. Each directed
// step pushes its hand-computed expected outputs into a queue; a monitor
// process pops one entry after every rising edge and compares it against the
// instance selected for that step.
// ---------------------------------------------------------------------------
module tb_deadlock_block_aggregator;

    logic       clock;
    logic       reset;
    logic [3:0] mon_block;
    logic       progress;
    logic       clear;

    logic        dl_a, pl_a;  logic [1:0] fi_a; logic [3:0] mk_a; logic [31:0] dc_a; logic [1:0] st_a;
    logic        dl_b, pl_b;  logic [1:0] fi_b; logic [3:0] mk_b; logic [31:0] dc_b; logic [1:0] st_b;
    logic        dl_c, pl_c;  logic [1:0] fi_c; logic [3:0] mk_c; logic [3:0]  dc_c; logic [1:0] st_c;

    deadlock_block_aggregator #(.NUM_MON(4), .THRESH(4), .CNT_W(32), .IDX_W(2)) dut_a (
        .clock(clock), .reset(reset), .mon_block(mon_block), .progress(progress), .clear(clear),
        .deadlock(dl_a), .deadlock_pulse(pl_a), .first_idx(fi_a), .blocked_mask(mk_a),
        .detect_cycle(dc_a), .state(st_a));

    deadlock_block_aggregator #(.NUM_MON(4), .THRESH(1), .CNT_W(32), .IDX_W(2)) dut_b (
        .clock(clock), .reset(reset), .mon_block(mon_block), .progress(progress), .clear(clear),
        .deadlock(dl_b), .deadlock_pulse(pl_b), .first_idx(fi_b), .blocked_mask(mk_b),
        .detect_cycle(dc_b), .state(st_b));

    deadlock_block_aggregator #(.NUM_MON(4), .THRESH(4), .CNT_W(4), .IDX_W(2)) dut_c (
        .clock(clock), .reset(reset), .mon_block(mon_block), .progress(progress), .clear(clear),
        .deadlock(dl_c), .deadlock_pulse(pl_c), .first_idx(fi_c), .blocked_mask(mk_c),
        .detect_cycle(dc_c), .state(st_c));

    typedef struct {
        string       nm;
        int          sel;
        logic [1:0]  st;
        logic        dl;
        logic        pl;
        logic [1:0]  fi;
        logic [3:0]  mk;
        logic [31:0] dc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cur_sel = 0;
    int   tcyc = 0;   // cyc value the DUTs sample at the upcoming edge

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, expv);
        end
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    initial begin
        exp_t e;
        logic [1:0] a_st; logic a_dl, a_pl; logic [1:0] a_fi; logic [3:0] a_mk; logic [31:0] a_dc;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                case (e.sel)
                    1: begin a_st = st_b; a_dl = dl_b; a_pl = pl_b; a_fi = fi_b; a_mk = mk_b; a_dc = dc_b; end
                    2: begin a_st = st_c; a_dl = dl_c; a_pl = pl_c; a_fi = fi_c; a_mk = mk_c; a_dc = {28'd0, dc_c}; end
                    default: begin a_st = st_a; a_dl = dl_a; a_pl = pl_a; a_fi = fi_a; a_mk = mk_a; a_dc = dc_a; end
                endcase
                cmp(e.nm, "state",        {30'd0, a_st}, {30'd0, e.st});
                cmp(e.nm, "deadlock",     {31'd0, a_dl}, {31'd0, e.dl});
                cmp(e.nm, "pulse",        {31'd0, a_pl}, {31'd0, e.pl});
                cmp(e.nm, "first_idx",    {30'd0, a_fi}, {30'd0, e.fi});
                cmp(e.nm, "blocked_mask", {28'd0, a_mk}, {28'd0, e.mk});
                cmp(e.nm, "detect_cycle", a_dc,          e.dc);
            end
        end
    end

    task automatic step(input string nm, input logic rst, input logic clr,
                        input logic [3:0] mb, input logic pg,
                        input logic [1:0] es, input logic edl, input logic ep,
                        input logic [1:0] ef, input logic [3:0] em, input logic [31:0] ed);
        exp_t e;
        @(negedge clock);
        reset = rst; clear = clr; mon_block = mb; progress = pg;
        e.nm = nm; e.sel = cur_sel; e.st = es; e.dl = edl; e.pl = ep;
        e.fi = ef; e.mk = em; e.dc = ed;
        q.push_back(e);
        tcyc = rst ? 0 : tcyc + 1;
    endtask

    task automatic do_reset(input string nm);
        step(nm, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'd0);
    endtask

    task automatic idle_until(input int target);
        while (tcyc < target)
            step("idle", 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'd0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; mon_block = '0; progress = 1'b0;

        // ---- THRESH=4 reference instance ----
        cur_sel = 0;
        do_reset("reset_a");
        idle_until(10);
        // Basic detect: blocking from cyc 10, deadlock on edge at cyc 13
        step("basic_c10", 0, 0, 4'b0100, 0, 2'd1, 0, 0, 2'd2, 4'b0100, 32'd0);
        step("basic_c11", 0, 0, 4'b0100, 0, 2'd1, 0, 0, 2'd2, 4'b0100, 32'd0);
        step("basic_c12", 0, 0, 4'b0100, 0, 2'd1, 0, 0, 2'd2, 4'b0100, 32'd0);
        step("basic_c13", 0, 0, 4'b0100, 0, 2'd2, 1, 1, 2'd2, 4'b0100, 32'd13);
        step("basic_c14", 0, 0, 4'b0100, 0, 2'd2, 1, 0, 2'd2, 4'b0100, 32'd13);
        step("sticky",    0, 0, 4'b1000, 1, 2'd2, 1, 0, 2'd2, 4'b0100, 32'd13);
        // Clear/re-arm with blocking continuing
        step("clear",     0, 1, 4'b0001, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        step("rearm_1",   0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("rearm_2",   0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("rearm_3",   0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("rearm_4",   0, 0, 4'b0001, 0, 2'd2, 1, 1, 2'd0, 4'b0001, 32'd20);
        step("rearm_5",   0, 0, 4'b0001, 0, 2'd2, 1, 0, 2'd0, 4'b0001, 32'd20);
        // Progress breaks an episode
        step("clr2",      0, 1, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        step("prog_1",    0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("prog_2",    0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("prog_3",    0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("prog_brk",  0, 0, 4'b0001, 1, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        step("prog_b1",   0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("prog_b2",   0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("prog_b3",   0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("prog_b4",   0, 0, 4'b0001, 0, 2'd2, 1, 1, 2'd0, 4'b0001, 32'd30);
        // Mask accumulation, first_idx stays on the first cycle's lowest bit
        step("clr3",      0, 1, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        step("mask_1",    0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("mask_2",    0, 0, 4'b0010, 0, 2'd1, 0, 0, 2'd0, 4'b0011, 32'd0);
        step("mask_3",    0, 0, 4'b0010, 0, 2'd1, 0, 0, 2'd0, 4'b0011, 32'd0);
        step("mask_4",    0, 0, 4'b1000, 0, 2'd2, 1, 1, 2'd0, 4'b1011, 32'd35);
        // Clear colliding with a blocked cycle at stall_cnt=3
        step("clr4",      0, 1, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        step("coll_1",    0, 0, 4'b0100, 0, 2'd1, 0, 0, 2'd2, 4'b0100, 32'd0);
        step("coll_2",    0, 0, 4'b0100, 0, 2'd1, 0, 0, 2'd2, 4'b0100, 32'd0);
        step("coll_3",    0, 0, 4'b0100, 0, 2'd1, 0, 0, 2'd2, 4'b0100, 32'd0);
        step("coll_clr",  0, 1, 4'b0100, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        step("coll_idle", 0, 0, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        step("coll_r1",   0, 0, 4'b0100, 0, 2'd1, 0, 0, 2'd2, 4'b0100, 32'd0);
        step("coll_r2",   0, 0, 4'b0100, 0, 2'd1, 0, 0, 2'd2, 4'b0100, 32'd0);
        step("coll_r3",   0, 0, 4'b0100, 0, 2'd1, 0, 0, 2'd2, 4'b0100, 32'd0);
        step("coll_r4",   0, 0, 4'b0100, 0, 2'd2, 1, 1, 2'd2, 4'b0100, 32'd45);
        // mon_block going to zero ends the episode
        step("clr5",      0, 1, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        step("zero_1",    0, 0, 4'b1000, 0, 2'd1, 0, 0, 2'd3, 4'b1000, 32'd0);
        step("zero_brk",  0, 0, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        // Reset mid-SUSPECT; cyc restarts at 0
        step("rst_s1",    0, 0, 4'b0010, 0, 2'd1, 0, 0, 2'd1, 4'b0010, 32'd0);
        step("rst_s2",    0, 0, 4'b0010, 0, 2'd1, 0, 0, 2'd1, 4'b0010, 32'd0);
        step("rst_mid",   1, 0, 4'b0010, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        step("rst_p1",    0, 0, 4'b0010, 0, 2'd1, 0, 0, 2'd1, 4'b0010, 32'd0);
        step("rst_p2",    0, 0, 4'b0010, 0, 2'd1, 0, 0, 2'd1, 4'b0010, 32'd0);
        step("rst_p3",    0, 0, 4'b0010, 0, 2'd1, 0, 0, 2'd1, 4'b0010, 32'd0);
        step("rst_p4",    0, 0, 4'b0010, 0, 2'd2, 1, 1, 2'd1, 4'b0010, 32'd3);

        // ---- THRESH=1 instance ----
        cur_sel = 1;
        do_reset("reset_b");
        step("t1_prog",   0, 0, 4'b1111, 1, 2'd0, 0, 0, 2'd0, 4'b0000, 32'd0);
        step("t1_det",    0, 0, 4'b0100, 0, 2'd2, 1, 1, 2'd2, 4'b0100, 32'd1);
        step("t1_hold",   0, 0, 4'b0011, 0, 2'd2, 1, 0, 2'd2, 4'b0100, 32'd1);

        // ---- CNT_W=4 instance: timestamp wraps 14,15,0,1 ----
        cur_sel = 2;
        do_reset("reset_c");
        idle_until(14);
        step("wrap_14",   0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("wrap_15",   0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("wrap_0",    0, 0, 4'b0001, 0, 2'd1, 0, 0, 2'd0, 4'b0001, 32'd0);
        step("wrap_1",    0, 0, 4'b0001, 0, 2'd2, 1, 1, 2'd0, 4'b0001, 32'd1);
        step("wrap_hold", 0, 0, 4'b0001, 0, 2'd2, 1, 0, 2'd0, 4'b0001, 32'd1);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clock);
        #3;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/deadlock_block_aggregator.md
Name: deadlock_block_aggregator

Overview:
Downstream consumer of the per-instance deadlock monitors in the HLS simulation harness. Collects the `block` outputs of NUM_MON monitors and a global progress indicator. Declares a deadlock only after THRESH consecutive cycles in which at least one monitor reports blocking and no progress occurs. Latches diagnostics (first blocking monitor, accumulated mask, detection timestamp) for the testbench to report.

Parameters:
NUM_MON, 4, number of monitor block inputs (>=1)
THRESH, 1000, consecutive blocked-without-progress cycles required to declare deadlock (>=1)
CNT_W, 32, width of free-running cycle timestamp
IDX_W, 2, width of first_idx; must satisfy 2^IDX_W >= NUM_MON

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
mon_block  in  NUM_MON  block output of monitor i on bit i
progress  in  1  high in any cycle where at least one stream/ap handshake completed
clear  in  1  synchronous re-arm; returns the block to IDLE
deadlock  out  1  sticky deadlock flag
deadlock_pulse  out  1  one-cycle strobe on the edge deadlock rises
first_idx  out  IDX_W  lowest set index of mon_block in first blocked cycle of episode
blocked_mask  out  NUM_MON  OR of mon_block over all blocked cycles of current episode
detect_cycle  out  CNT_W  cyc value of the cycle that completed THRESH
state  out  2  0=IDLE, 1=SUSPECT, 2=DEADLOCK (3 unused)

Behaviour:
- Reset: all outputs 0, state IDLE, internal stall_cnt 0, cyc 0.
- cyc: free-running; 0 after reset; +1 every cycle; wraps modulo 2^CNT_W; never frozen. clear does not affect it.
- C = (|mon_block) & ~progress, sampled each rising edge.
- stall_cnt: width clog2(THRESH+1); never exceeds THRESH.
- Priority each edge: reset > clear > state logic.
- clear in any state: next state IDLE; stall_cnt, blocked_mask, first_idx, detect_cycle and deadlock all 0. C in the same cycle is ignored.
- IDLE:
  - On C: stall_cnt<=1, blocked_mask<=mon_block, first_idx<=index of lowest set bit.
  - If 1>=THRESH, go to DEADLOCK on this edge. Otherwise go to SUSPECT.
  - On ~C: stay in IDLE.
- SUSPECT:
  - On C: blocked_mask |= mon_block.
  - If stall_cnt+1>=THRESH, go to DEADLOCK. Otherwise stall_cnt++.
  - On ~C (progress=1 or mon_block==0): go to IDLE; stall_cnt, blocked_mask and first_idx return to 0.
- Entry to DEADLOCK (same edge):
  - deadlock<=1.
  - deadlock_pulse<=1 for exactly one cycle.
  - detect_cycle<=current cyc.
  - blocked_mask includes this cycle's mon_block.
- DEADLOCK: sticky. Inputs are ignored except clear and reset. deadlock, first_idx, blocked_mask and detect_cycle are frozen. deadlock_pulse returns to 0 the next cycle.
- Latency: deadlock rises on the edge that samples the THRESH-th consecutive C cycle. No combinational input-to-output paths; all outputs registered.
- Simultaneous progress and mon_block!=0: counts as not blocked.
- mon_block values that change between set bits during an episode: still blocked. Only the mask grows; first_idx stays.

Test Plan:
(All use THRESH=4, NUM_MON=4 unless stated.)
1. Basic detect: mon_block=4'b0100, progress=0 from cyc=10 onward.
   -> state=1 after edge at cyc10.
   -> deadlock=1 and deadlock_pulse=1 after edge at cyc13; pulse 0 after cyc14.
   -> detect_cycle=13, first_idx=2, blocked_mask=4'b0100.
2. Progress breaks: 3 blocked cycles then progress=1 with mon_block still 4'b0001.
   -> state returns to 0, blocked_mask=0, deadlock stays 0.
   -> Next 4 blocked cycles declare deadlock.
3. Mask accumulation: mon_block sequence 0001,0010,0010,1000, progress=0.
   -> deadlock on 4th edge, first_idx=0, blocked_mask=4'b1011.
4. Clear/re-arm: in DEADLOCK assert clear one cycle while mon_block=4'b0001.
   -> next cycle state=0, all diagnostics 0.
   -> Blocking continues; deadlock re-asserts exactly 4 cycles after clear deasserts, with new detect_cycle.
5. Clear vs. C collision: clear=1 and C=1 in SUSPECT with stall_cnt=3.
   -> IDLE, deadlock stays 0, no pulse.
6. Corner configs:
   -> THRESH=1: single C cycle gives deadlock on that edge.
   -> reset asserted mid-SUSPECT: all outputs 0 and cyc=0 the following cycle.
   -> cyc wrap with CNT_W=4 started at 14: detect_cycle wraps correctly (e.g. 1).
